// File: rtl/ysyx_22050854_inst_fetch_buf.sv
// Instruction fetch buffer between SRAM_IFU and decode.
// Selects the 32-bit word from a 64-bit fetch beat by PC[2] and queues up to
// DEPTH instructions with their PC and an error tag. Decode sees a valid/ready
// stream, and flush drops all queued entries on a redirect.
// Optional macro YSYX_22050854_IFB_BYPASS_EN: when the buffer is empty, an
// incoming beat is forwarded straight to the output in the same cycle.
module ysyx_22050854_inst_fetch_buf #(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [PC_W-1:0] in_pc,
    input  logic [63:0]     in_rdata,
    input  logic            in_err,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [31:0]     out_inst,
    output logic            out_err,
    output logic [AW:0]     count
);

    localparam logic [AW:0] ONE = (AW+1)'(1);

    logic [PC_W-1:0] mem_pc   [DEPTH];
    logic [31:0]     mem_inst [DEPTH];
    logic            mem_err  [DEPTH];

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;

    logic        empty;
    logic        full;
    logic        push;
    logic        pop;
    logic        bypass;
    logic [31:0] in_word;
    logic        in_tag_err;

    assign empty      = (wr_ptr == rd_ptr);
    assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign in_ready   = ~full;
    assign in_word    = in_pc[2] ? in_rdata[63:32] : in_rdata[31:0];
    assign in_tag_err = in_err | (in_pc[1:0] != 2'b00);

`ifdef YSYX_22050854_IFB_BYPASS_EN
    assign bypass = empty & in_valid & ~flush;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed beat that decode takes in the same cycle is never stored.
    assign push = in_valid & in_ready & ~flush & ~(bypass & out_ready);
    assign pop  = ~empty & ~flush & out_ready;

    // Output stream: head entry, or the incoming beat when bypassing.
    always_comb begin
        out_valid = (~empty & ~flush) | bypass;
        out_pc    = mem_pc[rd_ptr[AW-1:0]];
        out_inst  = mem_inst[rd_ptr[AW-1:0]];
        out_err   = mem_err[rd_ptr[AW-1:0]];
        if (bypass) begin
            out_pc   = in_pc;
            out_inst = in_word;
            out_err  = in_tag_err;
        end
    end

    // Entry storage; only pointers are cleared on flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_pc[i]   <= '0;
                mem_inst[i] <= '0;
                mem_err[i]  <= 1'b0;
            end
        end else if (push) begin
            mem_pc[wr_ptr[AW-1:0]]   <= in_pc;
            mem_inst[wr_ptr[AW-1:0]] <= in_word;
            mem_err[wr_ptr[AW-1:0]]  <= in_tag_err;
        end
    end

    // Pointers and occupancy; flush wins over push and pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + ONE;
            if (pop)  rd_ptr <= rd_ptr + ONE;
            case ({push, pop})
                2'b10:   count <= count + ONE;
                2'b01:   count <= count - ONE;
                default: count <= count;
            endcase
        end
    end

    a_count_bound : assert property (@(posedge clk) disable iff (!rst_n) count <= (AW+1)'(DEPTH));
    a_no_push_full : assert property (@(posedge clk) disable iff (!rst_n) !(push && full));
    a_no_pop_empty : assert property (@(posedge clk) disable iff (!rst_n) !(pop && empty));

endmodule
